// File: rtl/mips_pkg.sv
// Shared encodings and instruction-field positions for the multicycle MIPS datapath.
package mips_pkg;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_NOR = 3'b100;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_HOLD   = 2'b11;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned IMM_MSB   = 15;
    localparam int unsigned JADDR_MSB = 25;
    localparam int unsigned FUNCT_MSB = 5;
    localparam int unsigned FUNCT_LSB = 0;

endpackage

// File: rtl/mips_regfile_p.sv
// Register file: two asynchronous read ports, one synchronous write port, r0 reads zero.
module mips_regfile_p #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREG  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] ra1,
    input  logic [$clog2(NREG)-1:0] ra2,
    input  logic [$clog2(NREG)-1:0] wa,
    input  logic [WIDTH-1:0]        wd,
    output logic [WIDTH-1:0]        rd1,
    output logic [WIDTH-1:0]        rd2
);

    logic [WIDTH-1:0] regs_q [NREG];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs_q[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : regs_q[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs_q[ra2];

endmodule

// File: rtl/mips_datapath_p.sv
// Parametrised multicycle MIPS datapath: PC/IR/Data/A/B/ALUOut, register file and inline ALU,
// steered by an external multicycle controller.
module mips_datapath_p
    import mips_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      NREG     = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IorD,
    input  logic             ALUSrcA,
    input  logic [1:0]       ALUSrcB,
    input  logic [2:0]       ALUControl,
    input  logic [1:0]       PCSrc,
    input  logic             PCWrite,
    input  logic             Branch,
    input  logic             IRWrite,
    input  logic             RegDst,
    input  logic             MemtoReg,
    input  logic             RegWrite,
    input  logic             MemWrite,
    input  logic [31:0]      RD,
    output logic [5:0]       OP,
    output logic [5:0]       Funct,
    output logic [WIDTH-1:0] Adr,
    output logic [WIDTH-1:0] WD,
    output logic             WE,
    output logic             ZeroQ,
    output logic             Overflow
);

    localparam int unsigned AW = $clog2(NREG);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [31:0]      ir_q;
    logic [WIDTH-1:0] data_q, a_q, b_q, aluout_q;
    logic             zero_q, ovf_q;

    logic [WIDTH-1:0] rd1, rd2, sign_imm, jump_target;
    logic [WIDTH-1:0] src_a, src_b, alu_res, reg_wd;
    logic [AW-1:0]    reg_wa;
    logic             zero, ovf, pc_en;

    assign sign_imm    = WIDTH'($signed(ir_q[IMM_MSB:0]));
    assign jump_target = {pc_q[WIDTH-1:28], ir_q[JADDR_MSB:0], 2'b00};

    assign reg_wa = RegDst ? ir_q[RD_LSB +: AW] : ir_q[RT_LSB +: AW];
    assign reg_wd = MemtoReg ? data_q : aluout_q;

    mips_regfile_p #(
        .WIDTH(WIDTH),
        .NREG (NREG)
    ) u_regfile (
        .clk  (clk),
        .reset(reset),
        .we   (RegWrite),
        .ra1  (ir_q[RS_LSB +: AW]),
        .ra2  (ir_q[RT_LSB +: AW]),
        .wa   (reg_wa),
        .wd   (reg_wd),
        .rd1  (rd1),
        .rd2  (rd2)
    );

    always_comb begin
        src_a = ALUSrcA ? a_q : pc_q;
        src_b = b_q;
        case (ALUSrcB)
            SRCB_B:      src_b = b_q;
            SRCB_FOUR:   src_b = WIDTH'(4);
            SRCB_IMM:    src_b = sign_imm;
            SRCB_IMM_SH: src_b = {sign_imm[WIDTH-3:0], 2'b00};
            default:     src_b = b_q;
        endcase
    end

    always_comb begin
        alu_res = '0;
        ovf     = 1'b0;
        case (ALUControl)
            ALU_ADD: begin
                alu_res = src_a + src_b;
                ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (alu_res[WIDTH-1] != src_a[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res = src_a - src_b;
                ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (alu_res[WIDTH-1] != src_a[WIDTH-1]);
            end
            ALU_AND: alu_res = src_a & src_b;
            ALU_OR:  alu_res = src_a | src_b;
            ALU_SLT: alu_res = WIDTH'($signed(src_a) < $signed(src_b));
            ALU_NOR: alu_res = ~(src_a | src_b);
            default: alu_res = '0;
        endcase
    end

    assign zero  = (alu_res == '0);
    assign pc_en = PCWrite | (Branch & zero);

    always_comb begin
        pc_d = pc_q;
        case (PCSrc)
            PC_SRC_ALU:    pc_d = alu_res;
            PC_SRC_ALUOUT: pc_d = aluout_q;
            PC_SRC_JUMP:   pc_d = jump_target;
            PC_SRC_HOLD:   pc_d = pc_q;
            default:       pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            data_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (pc_en) pc_q <= pc_d;
            if (IRWrite) ir_q <= RD;
            data_q   <= WIDTH'(RD);
            a_q      <= rd1;
            b_q      <= rd2;
            aluout_q <= alu_res;
            zero_q   <= zero;
            ovf_q    <= ovf;
        end
    end

    assign OP       = ir_q[OP_MSB:OP_LSB];
    assign Funct    = ir_q[FUNCT_MSB:FUNCT_LSB];
    assign Adr      = IorD ? aluout_q : pc_q;
    assign WD       = b_q;
    assign WE       = MemWrite;
    assign ZeroQ    = zero_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_mips_datapath_p.sv
// Bench for mips_datapath_p: a 32-bit/32-reg and a 64-bit/8-reg instance driven in lockstep.
module tb_mips_datapath_p;
    import mips_pkg::*;

    localparam logic [31:0] RPC32 = 32'h0040_0000;
    localparam logic [63:0] RPC64 = 64'h0000_0000_0000_1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        IorD, ALUSrcA, PCWrite, Branch, IRWrite, RegDst, MemtoReg, RegWrite, MemWrite;
    logic [1:0]  ALUSrcB, PCSrc;
    logic [2:0]  ALUControl;
    logic [31:0] RD;

    logic [5:0]  op32, fn32, op64, fn64;
    logic [31:0] adr32, wd32;
    logic [63:0] adr64, wd64;
    logic        we32, zq32, ov32, we64, zq64, ov64;

    always #5 clk = ~clk;

    mips_datapath_p #(.WIDTH(32), .NREG(32), .RESET_PC(RPC32)) dut32 (
        .clk(clk), .reset(reset), .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .PCSrc(PCSrc), .PCWrite(PCWrite), .Branch(Branch),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .RD(RD), .OP(op32), .Funct(fn32), .Adr(adr32), .WD(wd32),
        .WE(we32), .ZeroQ(zq32), .Overflow(ov32)
    );

    mips_datapath_p #(.WIDTH(64), .NREG(8), .RESET_PC(RPC64)) dut64 (
        .clk(clk), .reset(reset), .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .PCSrc(PCSrc), .PCWrite(PCWrite), .Branch(Branch),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .RD(RD), .OP(op64), .Funct(fn64), .Adr(adr64), .WD(wd64),
        .WE(we64), .ZeroQ(zq64), .Overflow(ov64)
    );

    typedef enum int {
        S_ADR32, S_OP32, S_FN32, S_WD32, S_ZQ32, S_OV32, S_WE32,
        S_ADR64, S_OP64, S_WD64, S_ZQ64, S_OV64
    } sel_t;

    typedef struct {
        string       name;
        sel_t        sel;
        logic [63:0] exp;
    } sb_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] r32;
        logic        ov32;
        logic [63:0] r64;
        logic        ov64;
    } vec_t;

    sb_t         sb[$];
    vec_t        vecs[10];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] pc32;
    logic [63:0] pc64;

    function automatic logic [63:0] observe(sel_t s);
        case (s)
            S_ADR32: return {32'h0, adr32};
            S_OP32:  return {58'h0, op32};
            S_FN32:  return {58'h0, fn32};
            S_WD32:  return {32'h0, wd32};
            S_ZQ32:  return {63'h0, zq32};
            S_OV32:  return {63'h0, ov32};
            S_WE32:  return {63'h0, we32};
            S_ADR64: return adr64;
            S_OP64:  return {58'h0, op64};
            S_WD64:  return wd64;
            S_ZQ64:  return {63'h0, zq64};
            S_OV64:  return {63'h0, ov64};
            default: return 64'h0;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_push(input string name, input sel_t s, input logic [63:0] e);
        sb_t item;
        item.name = name;
        item.sel  = s;
        item.exp  = e;
        sb.push_back(item);
    endtask

    // One clock; expectations queued before the edge are compared just after it.
    task automatic tick();
        sb_t item;
        @(posedge clk);
        #1;
        while (sb.size() != 0) begin
            item = sb.pop_front();
            check(item.name, observe(item.sel), item.exp);
        end
    endtask

    task automatic idle();
        IorD = 0; ALUSrcA = 0; ALUSrcB = 2'b00; ALUControl = ALU_ADD; PCSrc = PC_SRC_HOLD;
        PCWrite = 0; Branch = 0; IRWrite = 0; RegDst = 0; MemtoReg = 0; RegWrite = 0;
        MemWrite = 0;
    endtask

    task automatic set_ir(input logic [31:0] instr);
        RD = instr;
        IRWrite = 1;
        tick();
        IRWrite = 0;
    endtask

    // Loads a value through the Data register into reg[rt].
    task automatic write_reg(input logic [4:0] idx, input logic [31:0] val);
        set_ir({6'h23, 5'd0, idx, 16'h0});
        RD = val;
        tick();
        RegWrite = 1; MemtoReg = 1; RegDst = 0;
        tick();
        RegWrite = 0; MemtoReg = 0;
    endtask

    task automatic branch_seq(input string tag, input logic pcw, input logic taken);
        set_ir(32'h1022_0003);                       // beq r1, r2, +3
        ALUSrcA = 0; ALUSrcB = SRCB_IMM_SH; ALUControl = ALU_ADD;
        tick();
        ALUSrcA = 1; ALUSrcB = SRCB_B; ALUControl = ALU_SUB; Branch = 1; PCWrite = pcw;
        PCSrc = PC_SRC_ALUOUT;
        if (taken) begin
            pc32 = pc32 + 32'd12;
            pc64 = pc64 + 64'd12;
        end
        sb_push({tag, "_pc32"}, S_ADR32, {32'h0, pc32});
        sb_push({tag, "_pc64"}, S_ADR64, pc64);
        sb_push({tag, "_zq32"}, S_ZQ32, {63'h0, taken});
        tick();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{32'h7FFF_FFFF, 32'h1,         ALU_ADD, 32'h8000_0000, 1'b1,
                    64'h0000_0000_8000_0000, 1'b0};
        vecs[1] = '{32'h0,         32'h1,         ALU_SUB, 32'hFFFF_FFFF, 1'b0,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[2] = '{32'hFFFF_FFFF, 32'h1,         ALU_ADD, 32'h0,         1'b0,
                    64'h0000_0001_0000_0000, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h1,         ALU_SUB, 32'h7FFF_FFFF, 1'b1,
                    64'h0000_0000_7FFF_FFFF, 1'b0};
        vecs[4] = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_AND, 32'h00F0_00F0, 1'b0,
                    64'h0000_0000_00F0_00F0, 1'b0};
        vecs[5] = '{32'hF0F0_F0F0, 32'h0FF0_0FF0, ALU_OR,  32'hFFF0_FFF0, 1'b0,
                    64'h0000_0000_FFF0_FFF0, 1'b0};
        vecs[6] = '{32'h8000_0000, 32'h1,         ALU_SLT, 32'h1,         1'b0,
                    64'h0,                   1'b0};
        vecs[7] = '{32'h0F0F_0F0F, 32'h0,         ALU_NOR, 32'hF0F0_F0F0, 1'b0,
                    64'hFFFF_FFFF_F0F0_F0F0, 1'b0};
        vecs[8] = '{32'h5,         32'h5,         ALU_SUB, 32'h0,         1'b0,
                    64'h0,                   1'b0};
        vecs[9] = '{32'h5,         32'h3,         3'b011,  32'h0,         1'b0,
                    64'h0,                   1'b0};

        idle();
        RD = 32'h0;
        reset = 1;
        pc32 = RPC32;
        pc64 = RPC64;
        repeat (2) @(posedge clk);
        #1;
        check("rst_adr32", {32'h0, adr32}, {32'h0, RPC32});
        check("rst_adr64", adr64, RPC64);
        check("rst_op32", {58'h0, op32}, 64'h0);
        check("rst_ov32", {63'h0, ov32}, 64'h0);
        check("rst_wd64", wd64, 64'h0);
        MemWrite = 1;
        #1;
        check("we_high", {63'h0, we32}, 64'h1);
        MemWrite = 0;
        #1;
        check("we_low", {63'h0, we64}, 64'h0);
        reset = 0;

        // Fetch: IR <= lw, PC <= PC + 4
        RD = 32'h8C08_0004; IRWrite = 1; ALUSrcA = 0; ALUSrcB = SRCB_FOUR;
        ALUControl = ALU_ADD; PCSrc = PC_SRC_ALU; PCWrite = 1;
        sb_push("fetch_op32", S_OP32, 64'h23);
        sb_push("fetch_op64", S_OP64, 64'h23);
        sb_push("fetch_fn32", S_FN32, 64'h04);
        sb_push("fetch_pc32", S_ADR32, {32'h0, RPC32 + 32'd4});
        sb_push("fetch_pc64", S_ADR64, RPC64 + 64'd4);
        tick();
        idle();

        // Reset in the middle of a clock high phase takes effect without an edge.
        #3 reset = 1;
        #1;
        check("midrst_pc32", {32'h0, adr32}, {32'h0, RPC32});
        check("midrst_pc64", adr64, RPC64);
        check("midrst_op32", {58'h0, op32}, 64'h0);
        tick();
        reset = 0;
        pc32 = RPC32;
        pc64 = RPC64;

        for (int i = 0; i < 10; i++) begin
            write_reg(5'd1, vecs[i].a);
            write_reg(5'd2, vecs[i].b);
            set_ir({6'h0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20});
            sb_push($sformatf("vec%0d_b32", i), S_WD32, {32'h0, vecs[i].b});
            sb_push($sformatf("vec%0d_b64", i), S_WD64, {32'h0, vecs[i].b});
            tick();
            ALUSrcA = 1; ALUSrcB = SRCB_B; ALUControl = vecs[i].op; IorD = 1;
            sb_push($sformatf("vec%0d_res32", i), S_ADR32, {32'h0, vecs[i].r32});
            sb_push($sformatf("vec%0d_ov32", i), S_OV32, {63'h0, vecs[i].ov32});
            sb_push($sformatf("vec%0d_zq32", i), S_ZQ32, {63'h0, vecs[i].r32 == 32'h0});
            sb_push($sformatf("vec%0d_res64", i), S_ADR64, vecs[i].r64);
            sb_push($sformatf("vec%0d_ov64", i), S_OV64, {63'h0, vecs[i].ov64});
            sb_push($sformatf("vec%0d_zq64", i), S_ZQ64, {63'h0, vecs[i].r64 == 64'h0});
            tick();
            idle();
        end

        write_reg(5'd1, 32'd5);
        write_reg(5'd2, 32'd5);
        branch_seq("beq_taken", 1'b0, 1'b1);
        write_reg(5'd2, 32'd6);
        branch_seq("beq_not", 1'b0, 1'b0);
        write_reg(5'd2, 32'd5);
        branch_seq("beq_pcw", 1'b1, 1'b1);

        PCWrite = 1; PCSrc = PC_SRC_HOLD;
        sb_push("pc_hold32", S_ADR32, {32'h0, pc32});
        sb_push("pc_hold64", S_ADR64, pc64);
        tick();
        idle();

        set_ir(32'h0800_0010);
        PCWrite = 1; PCSrc = PC_SRC_JUMP;
        sb_push("jump_pc32", S_ADR32, 64'h40);
        sb_push("jump_pc64", S_ADR64, 64'h40);
        tick();
        idle();

        write_reg(5'd0, 32'h0000_DEAD);
        set_ir(32'h0);
        sb_push("r0_32", S_WD32, 64'h0);
        sb_push("r0_64", S_WD64, 64'h0);
        tick();

        // rd = 5'b01011: index 11 on the 32-reg file, index 3 on the 8-reg file.
        set_ir({6'h0, 5'd0, 5'd0, 5'b01011, 11'h0});
        RD = 32'h0000_BEEF;
        tick();
        RegWrite = 1; MemtoReg = 1; RegDst = 1;
        tick();
        idle();
        set_ir({6'h0, 5'd0, 5'd3, 16'h0});
        sb_push("rd11_r3_32", S_WD32, 64'h0);
        sb_push("rd11_r3_64", S_WD64, 64'hBEEF);
        tick();
        set_ir({6'h0, 5'd0, 5'd11, 16'h0});
        sb_push("rd11_r11_32", S_WD32, 64'hBEEF);
        sb_push("rd11_r11_64", S_WD64, 64'hBEEF);
        tick();

        // Read during write returns the old value; the new one appears a cycle later.
        write_reg(5'd4, 32'h111);
        set_ir({6'h23, 5'd0, 5'd4, 16'h0});
        RD = 32'h222;
        tick();
        RegWrite = 1; MemtoReg = 1;
        sb_push("rdw_old32", S_WD32, 64'h111);
        sb_push("rdw_old64", S_WD64, 64'h111);
        tick();
        idle();
        sb_push("rdw_new32", S_WD32, 64'h222);
        sb_push("rdw_new64", S_WD64, 64'h222);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
